imem_loader: RTL

- Boot-time program loader that sits directly upstream of the processor's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instructions.
- Writes each instruction into instruction memory at sequential word addresses.
- Holds the processor in reset until the image is loaded; the processor top ORs cpu_hold_po into its reset.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_csum.sv | 21 ++
 rtl/imem_loader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared loader state encoding and instruction-memory constants
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CSUM,
    DONE,
    ERR
  } load_state_t;

  localparam int INSTR_W        = 16;
  localparam int DEFAULT_ADDR_W = 8;

endpackage

// File: rtl/imem_loader_csum.sv
// rtl/imem_loader_csum.sv - running XOR accumulator over accepted stream bytes
module imem_loader_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot byte-stream loader writing 16-bit words into instruction memory
// Optional trailing XOR checksum byte is enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic               clk_pi,
  input  logic               reset_n_pi,
  input  logic               byte_valid_pi,
  input  logic [7:0]         byte_data_pi,
  output logic               byte_ready_po,
  input  logic               load_req_pi,
  output logic               imem_wr_en_po,
  output logic [ADDR_W-1:0]  imem_wr_addr_po,
  output logic [INSTR_W-1:0] imem_wr_data_po,
  output logic               cpu_hold_po,
  output logic               done_po,
  output logic               err_po
);

  // One bit wider than the address so a full-capacity image does not wrap.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam load_state_t END_STATE = CSUM;
`else
  localparam load_state_t END_STATE = DONE;
`endif

  load_state_t      state, next_state;
  logic [15:0]      len_q;
  logic [7:0]       hi_q;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             reload;
  logic [15:0]      len_full;
  logic             last_word;
  logic             ready_d, hold_d, done_d, err_d, wr_en_d;

  assign accept    = byte_valid_pi & byte_ready_po;
  assign reload    = load_req_pi & ((state == DONE) | (state == ERR));
  assign len_full  = {len_q[15:8], byte_data_pi};
  assign last_word = (17'(count) + 17'd1) == {1'b0, len_q};

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_acc;

  imem_loader_csum u_csum (
    .clk   (clk_pi),
    .rst_n (reset_n_pi),
    .clr   (reload),
    .en    (accept & (state != CSUM)),
    .data  (byte_data_pi),
    .acc   (csum_acc)
  );
`endif

  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      state         <= LEN_HI;
      byte_ready_po <= 1'b1;
      cpu_hold_po   <= 1'b1;
      done_po       <= 1'b0;
      err_po        <= 1'b0;
      imem_wr_en_po <= 1'b0;
    end else begin
      state         <= next_state;
      byte_ready_po <= ready_d;
      cpu_hold_po   <= hold_d;
      done_po       <= done_d;
      err_po        <= err_d;
      imem_wr_en_po <= wr_en_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      LEN_HI:  if (accept) next_state = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_full} > MAX_WORDS) next_state = ERR;
          else if (len_full == 16'd0)       next_state = END_STATE;
          else                              next_state = DATA_HI;
        end
      end
      DATA_HI: if (accept) next_state = DATA_LO;
      DATA_LO: if (accept) next_state = last_word ? END_STATE : DATA_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM:    if (accept) next_state = (byte_data_pi == csum_acc) ? DONE : ERR;
`endif
      DONE:    if (load_req_pi) next_state = LEN_HI;
      ERR:     if (load_req_pi) next_state = LEN_HI;
      default: next_state = LEN_HI;
    endcase
  end

  // Registered outputs are decoded from the next state so they move on the transition edge.
  always_comb begin
    ready_d = (next_state == LEN_HI) | (next_state == LEN_LO) |
              (next_state == DATA_HI) | (next_state == DATA_LO) |
              (next_state == CSUM);
    hold_d  = (next_state != DONE);
    done_d  = (next_state == DONE);
    err_d   = (next_state == ERR);
    wr_en_d = accept & (state == DATA_LO);
  end

  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      len_q           <= '0;
      hi_q            <= '0;
      count           <= '0;
      imem_wr_addr_po <= '0;
      imem_wr_data_po <= '0;
    end else begin
      if (accept && state == LEN_HI)  len_q[15:8] <= byte_data_pi;
      if (accept && state == LEN_LO)  len_q[7:0]  <= byte_data_pi;
      if (accept && state == DATA_HI) hi_q        <= byte_data_pi;
      if (reload) begin
        count <= '0;
      end else if (accept && state == DATA_LO) begin
        count           <= count + 1'b1;
        imem_wr_addr_po <= count[ADDR_W-1:0];
        imem_wr_data_po <= {hi_q, byte_data_pi};
      end
    end
  end

endmodule
